// File: rtl/vmem_pkg.sv
// Shared types for the vector-memory issue controller: FSM state encoding and stats counter width.
// NCORES falls back to 4 when the build does not define it.
`ifndef NCORES
`define NCORES 4
`endif

package vmem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } vmem_state_e;

    localparam int STATS_CNT_W = 32;

endpackage

// File: rtl/vmem_issue_ctrl_arbiter.sv
// Round-robin selector: picks the first valid requester at or after rr_ptr_i, wrapping cyclically.
module single_issue_arbiter #(
    parameter  int NCORES = 4,
    localparam int IDXW   = $clog2(NCORES)
) (
    input  logic [IDXW-1:0]   rr_ptr_i,
    input  logic [NCORES-1:0] req_valid_i,
    output logic              valid_o,
    output logic [IDXW-1:0]   selector_o
);

    // Walk offsets from farthest to nearest so the nearest valid requester is the one left standing.
    always_comb begin
        valid_o    = 1'b0;
        selector_o = '0;
        for (int off = NCORES - 1; off >= 0; off--) begin
            int idx;
            idx = int'(rr_ptr_i) + off;
            if (idx >= NCORES) begin
                idx = idx - NCORES;
            end
            if (req_valid_i[idx]) begin
                valid_o    = 1'b1;
                selector_o = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/vmem_issue_ctrl.sv
// Single-outstanding memory issue controller arbitrating NCORES cores onto one memory port.
// Define VMEM_ISSUE_STATS_EN to add per-core grant counters on grant_count_o.
module vmem_issue_ctrl
    import vmem_pkg::*;
#(
    parameter int NCORES     = `NCORES,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NCORES-1:0]                core_req_valid_i,
    input  logic [NCORES*ADDR_WIDTH-1:0]     core_req_addr_i,
    input  logic [NCORES-1:0]                core_req_we_i,
    input  logic [NCORES*DATA_WIDTH-1:0]     core_req_wdata_i,
    input  logic [NCORES*DATA_WIDTH/8-1:0]   core_req_wstrb_i,
    output logic [NCORES-1:0]                core_req_ready_o,
    output logic [NCORES-1:0]                core_resp_valid_o,
    output logic [DATA_WIDTH-1:0]            core_resp_rdata_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
    output logic                             mem_req_we_o,
    output logic [DATA_WIDTH-1:0]            mem_req_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          mem_req_wstrb_o,
    input  logic                             mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]            mem_resp_rdata_i
`ifdef VMEM_ISSUE_STATS_EN
    ,
    output logic [NCORES*STATS_CNT_W-1:0]    grant_count_o
`endif
);

    localparam int IDXW  = $clog2(NCORES);
    localparam int STRBW = DATA_WIDTH / 8;

    vmem_state_e            state_q, state_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]        grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRBW-1:0]       wstrb_q, wstrb_d;

    logic                   arb_valid;
    logic [IDXW-1:0]        arb_sel;
    logic                   accept;

    single_issue_arbiter #(
        .NCORES(NCORES)
    ) u_arb (
        .rr_ptr_i   (rr_ptr_q),
        .req_valid_i(core_req_valid_i),
        .valid_o    (arb_valid),
        .selector_o (arb_sel)
    );

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_d           = grant_q;
        addr_d            = addr_q;
        we_d              = we_q;
        wdata_d           = wdata_q;
        wstrb_d           = wstrb_q;
        accept            = 1'b0;
        mem_req_valid_o   = 1'b0;
        core_req_ready_o  = '0;
        core_resp_valid_o = '0;
        core_resp_rdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_sel;
                    for (int i = 0; i < NCORES; i++) begin
                        if (arb_sel == IDXW'(i)) begin
                            addr_d  = core_req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                            we_d    = core_req_we_i[i];
                            wdata_d = core_req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                            wstrb_d = core_req_wstrb_i[i*STRBW +: STRBW];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    accept                    = 1'b1;
                    core_req_ready_o[grant_q] = 1'b1;
                    // Explicit wrap so non-power-of-two core counts never point past the last core.
                    rr_ptr_d = (grant_q == IDXW'(NCORES - 1)) ? '0 : grant_q + IDXW'(1);
                    state_d  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    core_resp_valid_o[grant_q] = 1'b1;
                    core_resp_rdata_o          = mem_resp_rdata_i;
                    state_d                    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wstrb_o = wstrb_q;

`ifdef VMEM_ISSUE_STATS_EN
    logic [STATS_CNT_W-1:0] grant_cnt_q [NCORES];
    logic [STATS_CNT_W-1:0] grant_cnt_d [NCORES];

    // Counters bump on memory acceptance, not on the IDLE latch, and wrap naturally.
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (accept && (grant_q == IDXW'(i))) begin
                grant_cnt_d[i] = grant_cnt_q[i] + STATS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCORES; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            grant_count_o[i*STATS_CNT_W +: STATS_CNT_W] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_vmem_issue_ctrl.sv
// Scoreboard bench for vmem_issue_ctrl: directed scenarios followed by randomized traffic,
// checked each cycle against a transaction-level model of the issue rules.
module tb_vmem_issue_ctrl;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NC-1:0]     core_req_valid_i;
    logic [NC*AW-1:0]  core_req_addr_i;
    logic [NC-1:0]     core_req_we_i;
    logic [NC*DW-1:0]  core_req_wdata_i;
    logic [NC*SW-1:0]  core_req_wstrb_i;
    logic [NC-1:0]     core_req_ready_o;
    logic [NC-1:0]     core_resp_valid_o;
    logic [DW-1:0]     core_resp_rdata_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [AW-1:0]     mem_req_addr_o;
    logic              mem_req_we_o;
    logic [DW-1:0]     mem_req_wdata_o;
    logic [SW-1:0]     mem_req_wstrb_o;
    logic              mem_resp_valid_i;
    logic [DW-1:0]     mem_resp_rdata_i;
`ifdef VMEM_ISSUE_STATS_EN
    logic [NC*32-1:0]  grant_count_o;
`endif

    vmem_issue_ctrl #(
        .NCORES    (NC),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .core_req_valid_i (core_req_valid_i),
        .core_req_addr_i  (core_req_addr_i),
        .core_req_we_i    (core_req_we_i),
        .core_req_wdata_i (core_req_wdata_i),
        .core_req_wstrb_i (core_req_wstrb_i),
        .core_req_ready_o (core_req_ready_o),
        .core_resp_valid_o(core_resp_valid_o),
        .core_resp_rdata_o(core_resp_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_req_wstrb_o  (mem_req_wstrb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_rdata_i (mem_resp_rdata_i)
`ifdef VMEM_ISSUE_STATS_EN
        ,
        .grant_count_o    (grant_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            core;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    int checks = 0;
    int errors = 0;

    // Reference model: transaction phase 0 = free, 1 = offered to memory, 2 = awaiting response.
    int            mPhase = 0;
    int            mRr = 0;
    int            mGrant = 0;
    int            mGrantCnt [NC];
    req_t          reqQ [$];
    req_t          cur;
    bit            haveCur = 0;
    int            grantLog [$];
    logic          expReqValid;
    logic [NC-1:0] expReady;
    logic [NC-1:0] expRespValid;
    logic [DW-1:0] expRdata;
    logic [NC-1:0] lastReady = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setReq(input int c, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        core_req_valid_i[c]          = 1'b1;
        core_req_addr_i[c*AW +: AW]  = a;
        core_req_we_i[c]             = w;
        core_req_wdata_i[c*DW +: DW] = d;
        core_req_wstrb_i[c*SW +: SW] = s;
    endtask

    // Advance cycles; a core withdraws its request once it has seen its ready pulse.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk_i);
            #1;
            for (int c = 0; c < NC; c++) begin
                if (lastReady[c]) core_req_valid_i[c] = 1'b0;
            end
        end
    endtask

    // Model step then monitor comparison for the cycle that ends at the next rising edge.
    always @(negedge clk_i) begin
        expReqValid  = 1'b0;
        expReady     = '0;
        expRespValid = '0;
        expRdata     = '0;
        if (!rst_ni) begin
            mPhase  = 0;
            mRr     = 0;
            haveCur = 0;
            reqQ.delete();
            for (int c = 0; c < NC; c++) mGrantCnt[c] = 0;
            checkOutput("rst_mem_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
            checkOutput("rst_core_req_ready", {60'd0, core_req_ready_o}, 64'd0);
            checkOutput("rst_core_resp_valid", {60'd0, core_resp_valid_o}, 64'd0);
            checkOutput("rst_resp_rdata", {32'd0, core_resp_rdata_o}, 64'd0);
            checkOutput("rst_mem_addr", {32'd0, mem_req_addr_o}, 64'd0);
            checkOutput("rst_mem_payload", {27'd0, mem_req_we_o, mem_req_wdata_o, mem_req_wstrb_o}, 64'd0);
        end else begin
            case (mPhase)
                0: begin
                    if (core_req_valid_i != '0) begin
                        bit found;
                        req_t r;
                        found = 0;
                        for (int k = 0; k < NC; k++) begin
                            int c;
                            c = (mRr + k) % NC;
                            if (!found && core_req_valid_i[c]) begin
                                found  = 1;
                                mGrant = c;
                            end
                        end
                        r.core  = mGrant;
                        r.addr  = core_req_addr_i[mGrant*AW +: AW];
                        r.we    = core_req_we_i[mGrant];
                        r.wdata = core_req_wdata_i[mGrant*DW +: DW];
                        r.wstrb = core_req_wstrb_i[mGrant*SW +: SW];
                        reqQ.push_back(r);
                        mPhase = 1;
                    end
                end
                1: begin
                    expReqValid = 1'b1;
                    if (mem_req_ready_i) begin
                        expReady[mGrant] = 1'b1;
                        mRr              = (mGrant + 1) % NC;
                        mGrantCnt[mGrant]++;
                        mPhase           = 2;
                    end
                end
                default: begin
                    if (mem_resp_valid_i) begin
                        expRespValid[mGrant] = 1'b1;
                        expRdata             = mem_resp_rdata_i;
                        mPhase               = 0;
                    end
                end
            endcase
            checkOutput("mem_req_valid", {63'd0, mem_req_valid_o}, {63'd0, expReqValid});
            checkOutput("core_req_ready", {60'd0, core_req_ready_o}, {60'd0, expReady});
            checkOutput("core_resp_valid", {60'd0, core_resp_valid_o}, {60'd0, expRespValid});
            if (expRespValid != '0) begin
                checkOutput("core_resp_rdata", {32'd0, core_resp_rdata_o}, {32'd0, expRdata});
            end
            if (mem_req_valid_o) begin
                if (!haveCur) begin
                    checkOutput("req_expected", {63'd0, reqQ.size() > 0}, 64'd1);
                    if (reqQ.size() > 0) begin
                        cur     = reqQ.pop_front();
                        haveCur = 1;
                    end
                end
                if (haveCur) begin
                    checkOutput("mem_req_addr", {32'd0, mem_req_addr_o}, {32'd0, cur.addr});
                    checkOutput("mem_req_we", {63'd0, mem_req_we_o}, {63'd0, cur.we});
                    checkOutput("mem_req_wdata", {32'd0, mem_req_wdata_o}, {32'd0, cur.wdata});
                    checkOutput("mem_req_wstrb", {60'd0, mem_req_wstrb_o}, {60'd0, cur.wstrb});
                    if (core_req_ready_o != '0) begin
                        checkOutput("ready_core", {60'd0, core_req_ready_o}, {60'd0, 4'b0001 << cur.core});
                        haveCur = 0;
                    end
                end
            end
        end
        lastReady = rst_ni ? core_req_ready_o : '0;
        for (int c = 0; c < NC; c++) begin
            if (rst_ni && core_req_ready_o[c]) grantLog.push_back(c);
        end
    end

    task automatic pulseReset();
        rst_ni = 1'b0;
        applyStimulus(1);
        rst_ni = 1'b1;
    endtask

    initial begin
        int rrExp [5];
        int wrapExp [4];
        rrExp   = '{0, 1, 2, 3, 0};
        wrapExp = '{2, 0, 1, 0};
        rst_ni           = 1'b0;
        core_req_valid_i = '0;
        core_req_addr_i  = '0;
        core_req_we_i    = '0;
        core_req_wdata_i = '0;
        core_req_wstrb_i = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;
        applyStimulus(3);
        rst_ni = 1'b1;

        $display("[TB] single read from core 2");
        setReq(2, 32'h100, 1'b0, 32'h0, 4'h0);
        mem_req_ready_i = 1'b1;
        applyStimulus(1);
        @(negedge clk_i);
        checkOutput("single_addr", {32'd0, mem_req_addr_o}, 64'h100);
        checkOutput("single_ready", {60'd0, core_req_ready_o}, 64'b0100);
        applyStimulus(3);
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        checkOutput("single_resp_valid", {60'd0, core_resp_valid_o}, 64'b0100);
        checkOutput("single_resp_rdata", {32'd0, core_resp_rdata_o}, 64'hDEADBEEF);
        applyStimulus(1);
        mem_resp_valid_i = 1'b0;

        $display("[TB] round-robin with all cores requesting");
        pulseReset();
        grantLog.delete();
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            for (int c = 0; c < NC; c++) begin
                if (!core_req_valid_i[c]) setReq(c, 32'h1000 + c * 4, c[0], $urandom, 4'hF);
            end
            applyStimulus(1);
        end
        core_req_valid_i = '0;
        applyStimulus(4);
        checkOutput("rr_count", {63'd0, grantLog.size() >= 5}, 64'd1);
        for (int k = 0; k < 5 && k < grantLog.size(); k++) begin
            checkOutput($sformatf("rr_order_%0d", k), 64'(grantLog[k]), 64'(rrExp[k]));
        end

        $display("[TB] pointer wrap from core 3 to core 0");
        pulseReset();
        grantLog.delete();
        setReq(2, 32'h2000, 1'b1, 32'h55AA55AA, 4'h3);
        applyStimulus(2);
        setReq(1, 32'h2100, 1'b0, 32'h0, 4'h0);
        for (int t = 0; t < 16; t++) begin
            if (!core_req_valid_i[0]) setReq(0, 32'h2200 + t, 1'b0, 32'h0, 4'h0);
            applyStimulus(1);
        end
        core_req_valid_i = '0;
        applyStimulus(4);
        checkOutput("wrap_count", {63'd0, grantLog.size() >= 4}, 64'd1);
        for (int k = 0; k < 4 && k < grantLog.size(); k++) begin
            checkOutput($sformatf("wrap_order_%0d", k), 64'(grantLog[k]), 64'(wrapExp[k]));
        end

        $display("[TB] memory backpressure");
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        setReq(1, 32'hABC0, 1'b1, 32'hCAFEF00D, 4'hA);
        applyStimulus(1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_i);
            checkOutput("bp_valid_held", {63'd0, mem_req_valid_o}, 64'd1);
            checkOutput("bp_no_ready", {60'd0, core_req_ready_o}, 64'd0);
            checkOutput("bp_addr_held", {32'd0, mem_req_addr_o}, 64'hABC0);
            applyStimulus(1);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_ready_pulse", {60'd0, core_req_ready_o}, 64'b0010);
        applyStimulus(1);
        mem_resp_valid_i = 1'b1;
        applyStimulus(1);
        mem_resp_valid_i = 1'b0;

        $display("[TB] reset while awaiting response");
        setReq(1, 32'h3000, 1'b0, 32'h0, 4'h0);
        applyStimulus(3);
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("midrst_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
        checkOutput("midrst_addr", {32'd0, mem_req_addr_o}, 64'd0);
        applyStimulus(1);
        rst_ni           = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 32'h12345678;
        @(negedge clk_i);
        checkOutput("stray_resp_ignored", {60'd0, core_resp_valid_o}, 64'd0);
        applyStimulus(1);
        mem_resp_valid_i = 1'b0;
        grantLog.delete();
        setReq(2, 32'h3200, 1'b0, 32'h0, 4'h0);
        setReq(0, 32'h3300, 1'b0, 32'h0, 4'h0);
        mem_resp_valid_i = 1'b1;
        applyStimulus(8);
        mem_resp_valid_i = 1'b0;
        checkOutput("post_rst_grant_count", {63'd0, grantLog.size() >= 1}, 64'd1);
        if (grantLog.size() >= 1) checkOutput("post_rst_first_grant", 64'(grantLog[0]), 64'd0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 3000; t++) begin
            applyStimulus(1);
            rst_ni = ($urandom_range(0, 499) != 0);
            for (int c = 0; c < NC; c++) begin
                if (!core_req_valid_i[c] && $urandom_range(0, 3) == 0) begin
                    setReq(c, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
                end
            end
            mem_req_ready_i  = ($urandom_range(0, 2) != 0);
            mem_resp_valid_i = ($urandom_range(0, 2) == 0);
            mem_resp_rdata_i = $urandom;
        end
        rst_ni           = 1'b1;
        core_req_valid_i = '0;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b1;
        applyStimulus(6);

`ifdef VMEM_ISSUE_STATS_EN
        @(negedge clk_i);
        for (int c = 0; c < NC; c++) begin
            checkOutput($sformatf("grant_count_%0d", c), {32'd0, grant_count_o[c*32 +: 32]}, 64'(mGrantCnt[c]));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
